id_ex_stage: RTL

ID/EX stage of the RV32I pipeline: it registers decoded operands and control from ID, detects load-use hazards, and inserts bubbles. It also drives the IF/ID hold and applies branch flushes issued from EX. Its registered outputs feed the EX stage and the forwarding unit (rs1/rs2 indices, RegWrite, MemRead). A WB→ID write-through bypass means the register file needs no internal forwarding.

---
 rtl/rv_pipe_pkg.sv | 28 ++
 rtl/idex_hazard_detect.sv | 29 ++
 rtl/id_ex_stage.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared RV32I pipeline definitions: control-bus layout, bubble encoding and
// the write-back bypass match used by ID/EX.
package rv_pipe_pkg;

  localparam int CTRL_W = 10;

  localparam int CTRL_REGWRITE  = 9;
  localparam int CTRL_MEMREAD   = 8;
  localparam int CTRL_MEMWRITE  = 7;
  localparam int CTRL_MEMTOREG  = 6;
  localparam int CTRL_ALUSRC    = 5;
  localparam int CTRL_BRANCH    = 4;
  localparam int CTRL_ALUOP_MSB = 3;
  localparam int CTRL_ALUOP_LSB = 0;

  typedef logic [CTRL_W-1:0] ctrl_t;
  typedef logic [4:0]        reg_idx_t;

  // All-zero control word: no register write, no memory access.
  localparam ctrl_t CTRL_NOP = '0;

  // True when the register being written back this cycle is the one named by rs.
  function automatic logic wb_hits(input logic we, input reg_idx_t wb_rd,
                                   input reg_idx_t rs);
    return we && (wb_rd != 5'd0) && (wb_rd == rs);
  endfunction

endpackage

// File: rtl/idex_hazard_detect.sv
// Load-use hazard detection between the instruction in ID and a load sitting
// in ID/EX. Purely combinational so decode-side stall logic can reuse it.
module idex_hazard_detect
  import rv_pipe_pkg::*;
(
  input  logic     idex_valid,
  input  logic     idex_memread,
  input  reg_idx_t idex_rd,
  input  logic     id_valid,
  input  reg_idx_t id_rs1,
  input  reg_idx_t id_rs2,
  input  logic     id_uses_rs1,
  input  logic     id_uses_rs2,
  input  logic     id_memwrite,
  output logic     load_use
);

  logic rs1_hit;
  logic rs2_hit_nonstore;

  // Store data from a load is forwarded in MEM, so rs2 of a store never stalls.
  always_comb begin
    rs1_hit          = id_uses_rs1 && (id_rs1 == idex_rd);
    rs2_hit_nonstore = id_uses_rs2 && (id_rs2 == idex_rd) && !id_memwrite;
    load_use         = idex_valid && idex_memread && (idex_rd != 5'd0) &&
                       id_valid && (rs1_hit || rs2_hit_nonstore);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubbling, EX flush/stall handling and
// WB->ID write-through bypass. Define IDEX_STALL_CNT_EN for stall/bubble counters.
module id_ex_stage
  import rv_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_RegWrite,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ex_flush,
  input  logic              ex_stall,
  output logic              idex_valid,
  output logic [XLEN-1:0]   idex_pc,
  output logic [4:0]        idex_rs1,
  output logic [4:0]        idex_rs2,
  output logic [4:0]        idex_rd,
  output logic [XLEN-1:0]   idex_rs1_data,
  output logic [XLEN-1:0]   idex_rs2_data,
  output logic [XLEN-1:0]   idex_imm,
  output logic [CTRL_W-1:0] idex_ctrl,
  output logic              stall_if_id,
  output logic              load_use
`ifdef IDEX_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       bubble_count
`endif
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  reg_idx_t        rs1_q, rs1_d;
  reg_idx_t        rs2_q, rs2_d;
  reg_idx_t        rd_q, rd_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q, imm_d;
  ctrl_t           ctrl_q, ctrl_d;

  logic            load_use_det;
  logic [XLEN-1:0] id_rs1_byp;
  logic [XLEN-1:0] id_rs2_byp;
  logic            bubble_ins;

  idex_hazard_detect u_hazard (
    .idex_valid   (valid_q),
    .idex_memread (ctrl_q[CTRL_MEMREAD]),
    .idex_rd      (rd_q),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .id_memwrite  (id_ctrl[CTRL_MEMWRITE]),
    .load_use     (load_use_det)
  );

  // Gating with rst_n keeps both hazard outputs quiet while reset is held.
  always_comb begin
    load_use    = rst_n && load_use_det;
    stall_if_id = rst_n && !ex_flush && (ex_stall || load_use_det);
    bubble_ins  = ex_flush || (!ex_stall && load_use_det);
    id_rs1_byp  = wb_hits(wb_RegWrite, wb_rd, id_rs1) ? wb_data : id_rs1_data;
    id_rs2_byp  = wb_hits(wb_RegWrite, wb_rd, id_rs2) ? wb_data : id_rs2_data;
  end

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    ctrl_d     = ctrl_q;
    if (ex_flush || (!ex_stall && (load_use_det || !id_valid))) begin
      valid_d    = 1'b0;
      pc_d       = '0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      ctrl_d     = CTRL_NOP;
    end else if (ex_stall) begin
      // Held operands must not go stale when WB retires their source register.
      if (wb_hits(wb_RegWrite, wb_rd, rs1_q)) rs1_data_d = wb_data;
      if (wb_hits(wb_RegWrite, wb_rd, rs2_q)) rs2_data_d = wb_data;
    end else begin
      valid_d    = 1'b1;
      pc_d       = id_pc;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
      rs1_data_d = id_rs1_byp;
      rs2_data_d = id_rs2_byp;
      imm_d      = id_imm;
      ctrl_d     = id_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      ctrl_q     <= CTRL_NOP;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      ctrl_q     <= ctrl_d;
    end
  end

  assign idex_valid    = valid_q;
  assign idex_pc       = pc_q;
  assign idex_rs1      = rs1_q;
  assign idex_rs2      = rs2_q;
  assign idex_rd       = rd_q;
  assign idex_rs1_data = rs1_data_q;
  assign idex_rs2_data = rs2_data_q;
  assign idex_imm      = imm_q;
  assign idex_ctrl     = ctrl_q;

`ifdef IDEX_STALL_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] bubble_count_q, bubble_count_d;

  // Only bubbles forced by hazards or flushes count; idle ID slots do not.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    bubble_count_d = bubble_count_q;
    if (stall_if_id) stall_cycles_d = stall_cycles_q + 32'd1;
    if (bubble_ins)  bubble_count_d = bubble_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      bubble_count_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign bubble_count = bubble_count_q;
`else
  logic unused_bubble;
  assign unused_bubble = bubble_ins;
`endif

endmodule
